// File: rtl/whack_game_engine.sv
// Whack-a-mole game engine: synchronised buttons, IDLE/RUN/OVER FSM, tick prescaler,
// LFSR-randomised dark times and one lit/dark countdown per target channel.

module whack_chan #(
   parameter int CNT_W    = 3,
   parameter int ON_TICKS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             kill,
   input  logic             act,
   input  logic             tick,
   input  logic             press,
   input  logic [CNT_W-1:0] load_cnt,
   input  logic [CNT_W-1:0] dark_cnt,
   output logic             lit,
   output logic             hit,
   output logic             tmo,
   output logic             dpress
);
   logic             lit_q, lit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      lit_d  = lit_q;
      cnt_d  = cnt_q;
      hit    = 1'b0;
      tmo    = 1'b0;
      dpress = 1'b0;
      if (load) begin
         lit_d = 1'b0;
         cnt_d = load_cnt;
      end else if (kill) begin
         lit_d = 1'b0;
      end else if (act) begin
         // a press on a lit target beats a timeout landing in the same cycle
         if (lit_q && press) begin
            hit   = 1'b1;
            lit_d = 1'b0;
            cnt_d = dark_cnt;
         end else if (tick) begin
            if (cnt_q == CNT_W'(1)) begin
               if (lit_q) begin
                  tmo   = 1'b1;
                  lit_d = 1'b0;
                  cnt_d = dark_cnt;
               end else begin
                  lit_d = 1'b1;
                  cnt_d = CNT_W'(ON_TICKS);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         dpress = ~lit_q & press;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lit_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         lit_q <= lit_d;
         cnt_q <= cnt_d;
      end
   end

   assign lit = lit_q;
endmodule

module whack_game_engine #(
   parameter int          N_CH       = 4,
   parameter int          TICK_DIV   = 1000000,
   parameter int          ON_TICKS   = 50,
   parameter int          OFF_BASE   = 150,
   parameter int          OFF_MASK   = 255,
   parameter int          MISS_LIMIT = 10,
   parameter int          SCORE_W    = 16,
   parameter int          PENALTY    = 0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_CH-1:0]    btn_n,
   input  logic               start_n,
   output logic [N_CH-1:0]    lamp,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         miss,
   output logic               running,
   output logic               game_over,
   output logic               hit_pulse
);
   localparam int MASK_MAX = OFF_MASK & 16'hFFFF;
   localparam int DARK_MAX = OFF_BASE + ((N_CH - 1 > MASK_MAX) ? N_CH - 1 : MASK_MAX);
   localparam int CNT_MAX  = (ON_TICKS > DARK_MAX) ? ON_TICKS : DARK_MAX;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int PRE_W    = $clog2(TICK_DIV);
   localparam int SUM_W    = $clog2(N_CH + 1);
   localparam int SC_W     = SCORE_W + SUM_W;
   localparam int MS_W     = 8 + SUM_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   // bit N_CH carries start_n alongside the target buttons
   logic [N_CH:0] s1_q, s2_q, s3_q, press;
   logic [1:0]          state_q, state_d;
   logic [PRE_W-1:0]    presc_q, presc_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [7:0]          miss_q, miss_d;
   logic                hit_pulse_q, hit_pulse_d;
   logic                start_go, over_now, act, tick;
   logic [N_CH-1:0]     lit, hit, tmo, dpress, miss_ev;
   logic [SUM_W-1:0]    n_hit, n_miss;
   logic [SC_W-1:0]     score_sum;
   logic [MS_W-1:0]     miss_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '1;
         s2_q <= '1;
         s3_q <= '1;
      end else begin
         s1_q <= {start_n, btn_n};
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign press    = s3_q & ~s2_q;
   assign start_go = (state_q != ST_RUN) && press[N_CH];
   assign over_now = (state_q == ST_RUN) && (miss_q == 8'(MISS_LIMIT));
   assign act      = (state_q == ST_RUN) && !over_now;
   assign tick     = act && (presc_q == PRE_W'(TICK_DIV - 1));
   assign miss_ev  = tmo | ((PENALTY != 0) ? dpress : '0);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [15:0]      lfsr_sh;
      logic [CNT_W-1:0] dark_cnt;
      assign lfsr_sh  = lfsr_q >> i;
      assign dark_cnt = CNT_W'(OFF_BASE) + CNT_W'(lfsr_sh & 16'(OFF_MASK));

      whack_chan #(.CNT_W(CNT_W), .ON_TICKS(ON_TICKS)) u_chan (
         .clk(clk), .rst_n(rst_n), .load(start_go), .kill(over_now), .act(act),
         .tick(tick), .press(press[i]), .load_cnt(CNT_W'(OFF_BASE + i)),
         .dark_cnt(dark_cnt), .lit(lit[i]), .hit(hit[i]), .tmo(tmo[i]),
         .dpress(dpress[i])
      );
   end

   always_comb begin
      n_hit  = '0;
      n_miss = '0;
      for (int i = 0; i < N_CH; i++) begin
         n_hit  = n_hit + SUM_W'(hit[i]);
         n_miss = n_miss + SUM_W'(miss_ev[i]);
      end
      score_sum = SC_W'(score_q) + SC_W'(n_hit);
      miss_sum  = MS_W'(miss_q) + MS_W'(n_miss);
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      lfsr_d      = lfsr_q;
      score_d     = score_q;
      miss_d      = miss_q;
      hit_pulse_d = 1'b0;
      if (start_go) begin
         state_d = ST_RUN;
         presc_d = '0;
         score_d = '0;
         miss_d  = '0;
      end else if (over_now) begin
         state_d = ST_OVER;
      end else if (act) begin
         presc_d     = tick ? '0 : presc_q + PRE_W'(1);
         hit_pulse_d = |hit;
         score_d     = (score_sum > SC_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                            : score_sum[SCORE_W-1:0];
         miss_d      = (miss_sum > MS_W'(MISS_LIMIT)) ? 8'(MISS_LIMIT) : miss_sum[7:0];
         // Fibonacci taps 16,14,13,11
         if (tick) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         lfsr_q      <= LFSR_SEED;
         score_q     <= '0;
         miss_q      <= '0;
         hit_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         lfsr_q      <= lfsr_d;
         score_q     <= score_d;
         miss_q      <= miss_d;
         hit_pulse_q <= hit_pulse_d;
      end
   end

   assign lamp      = lit;
   assign score     = score_q;
   assign miss      = miss_q;
   assign running   = (state_q == ST_RUN);
   assign game_over = (state_q == ST_OVER);
   assign hit_pulse = hit_pulse_q;
endmodule

// File: tb/tb_whack_game_engine.sv
// Bench for whack_game_engine: per-game tables of button events and expected outputs,
// expectations queued at game start and compared at the cycle they fall due.

module tb_whack_game_engine;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] btn_n = 4'hF;
   logic       start_n = 1'b1;
   logic [3:0] lamp;
   logic [1:0] score;
   logic [7:0] miss;
   logic       running, game_over, hit_pulse;

   whack_game_engine #(
      .N_CH(4), .TICK_DIV(4), .ON_TICKS(3), .OFF_BASE(2), .OFF_MASK(0),
      .MISS_LIMIT(3), .SCORE_W(2), .PENALTY(1), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .start_n(start_n), .lamp(lamp),
      .score(score), .miss(miss), .running(running), .game_over(game_over),
      .hit_pulse(hit_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         g;
      int         r;
      logic       st;
      logic [3:0] prs;
      logic       chk;
      logic [3:0] lamp;
      logic [1:0] score;
      logic [7:0] miss;
      logic       run;
      logic       ovr;
      logic       hp;
   } vec_t;

   typedef struct {
      int   due;
      vec_t v;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic ev(input int g, input int r, input logic st, input logic [3:0] prs);
      vec_t v;
      v = '{g: g, r: r, st: st, prs: prs, chk: 1'b0, lamp: 4'h0, score: 2'd0,
            miss: 8'd0, run: 1'b0, ovr: 1'b0, hp: 1'b0};
      vecs.push_back(v);
   endtask

   task automatic ex(input int g, input int r, input logic [3:0] lmp, input int sc,
                     input int ms, input logic rn, input logic ov, input logic hp);
      vec_t v;
      v = '{g: g, r: r, st: 1'b0, prs: 4'h0, chk: 1'b1, lamp: lmp, score: 2'(sc),
            miss: 8'(ms), run: rn, ovr: ov, hp: hp};
      vecs.push_back(v);
   endtask

   task automatic check_due();
      exp_t  e;
      string t;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         t = $sformatf("g%0d r%0d", e.v.g, e.v.r);
         if (e.due != cyc) chk({t, " late"}, cyc, e.due);
         chk({t, " lamp"},      int'(lamp),      int'(e.v.lamp));
         chk({t, " score"},     int'(score),     int'(e.v.score));
         chk({t, " miss"},      int'(miss),      int'(e.v.miss));
         chk({t, " running"},   int'(running),   int'(e.v.run));
         chk({t, " game_over"}, int'(game_over), int'(e.v.ovr));
         chk({t, " hit_pulse"}, int'(hit_pulse), int'(e.v.hp));
      end
   endtask

   // r counts clk edges from the negedge where start_n is driven low
   task automatic run_game(input int g, input int len);
      int         s;
      logic [3:0] cur, prv;
      logic       stc, stp;
      exp_t       e;
      @(negedge clk);
      s = cyc;
      foreach (vecs[k]) begin
         if (vecs[k].g == g && vecs[k].chk) begin
            e.due = s + vecs[k].r;
            e.v   = vecs[k];
            sb.push_back(e);
         end
      end
      prv = 4'h0;
      stp = 1'b0;
      for (int r = 0; r <= len; r++) begin
         if (r > 0) @(negedge clk);
         check_due();
         cur = 4'h0;
         stc = (r == 0);
         foreach (vecs[k]) begin
            if (vecs[k].g == g && vecs[k].r == r && !vecs[k].chk) begin
               cur = cur | vecs[k].prs;
               stc = stc | vecs[k].st;
            end
         end
         btn_n   = ~(cur | prv);
         start_n = ~(stc | stp);
         prv = cur;
         stp = stc;
      end
      btn_n   = 4'hF;
      start_n = 1'b1;
   endtask

   task automatic reset_check(input string nm);
      chk({nm, " lamp"},      int'(lamp),      0);
      chk({nm, " score"},     int'(score),     0);
      chk({nm, " miss"},      int'(miss),      0);
      chk({nm, " running"},   int'(running),   0);
      chk({nm, " game_over"}, int'(game_over), 0);
      chk({nm, " hit_pulse"}, int'(hit_pulse), 0);
   endtask

   initial begin
      // game 1: no presses, stagger then three timeouts end the game
      ex(1, 2, 4'b0000, 0, 0, 0, 0, 0);
      ex(1, 3, 4'b0000, 0, 0, 1, 0, 0);
      ex(1, 10, 4'b0000, 0, 0, 1, 0, 0);
      ex(1, 11, 4'b0001, 0, 0, 1, 0, 0);
      ex(1, 15, 4'b0011, 0, 0, 1, 0, 0);
      ex(1, 19, 4'b0111, 0, 0, 1, 0, 0);
      ex(1, 22, 4'b0111, 0, 0, 1, 0, 0);
      ex(1, 23, 4'b1110, 0, 1, 1, 0, 0);
      ex(1, 27, 4'b1100, 0, 2, 1, 0, 0);
      ex(1, 31, 4'b1001, 0, 3, 1, 0, 0);
      ex(1, 32, 4'b0000, 0, 3, 0, 1, 0);
      ev(1, 34, 1'b0, 4'b0001);
      ex(1, 40, 4'b0000, 0, 3, 0, 1, 0);
      // game 2: single hit, double hit, dark-press penalty, score saturation, start ignored
      ex(2, 2, 4'b0000, 0, 3, 0, 1, 0);
      ex(2, 3, 4'b0000, 0, 0, 1, 0, 0);
      ex(2, 11, 4'b0001, 0, 0, 1, 0, 0);
      ev(2, 13, 1'b0, 4'b0001);
      ex(2, 15, 4'b0011, 0, 0, 1, 0, 0);
      ex(2, 16, 4'b0010, 1, 0, 1, 0, 1);
      ex(2, 17, 4'b0010, 1, 0, 1, 0, 0);
      ex(2, 19, 4'b0110, 1, 0, 1, 0, 0);
      ev(2, 21, 1'b0, 4'b0110);
      ex(2, 23, 4'b1111, 1, 0, 1, 0, 0);
      ex(2, 24, 4'b1001, 3, 0, 1, 0, 1);
      ev(2, 25, 1'b0, 4'b0010);
      ex(2, 25, 4'b1001, 3, 0, 1, 0, 0);
      ex(2, 28, 4'b1001, 3, 1, 1, 0, 0);
      ev(2, 29, 1'b0, 4'b0001);
      ex(2, 31, 4'b1111, 3, 1, 1, 0, 0);
      ex(2, 32, 4'b1110, 3, 1, 1, 0, 1);
      ev(2, 33, 1'b1, 4'b0000);
      ex(2, 37, 4'b0110, 3, 2, 1, 0, 0);
      // game 3 after mid-game reset: stagger restarts, hit on the timeout tick
      ex(3, 2, 4'b0000, 0, 0, 0, 0, 0);
      ex(3, 3, 4'b0000, 0, 0, 1, 0, 0);
      ex(3, 11, 4'b0001, 0, 0, 1, 0, 0);
      ex(3, 15, 4'b0011, 0, 0, 1, 0, 0);
      ex(3, 19, 4'b0111, 0, 0, 1, 0, 0);
      ev(3, 20, 1'b0, 4'b0001);
      ex(3, 22, 4'b0111, 0, 0, 1, 0, 0);
      ex(3, 23, 4'b1110, 1, 0, 1, 0, 1);
      ex(3, 24, 4'b1110, 1, 0, 1, 0, 0);
      ex(3, 27, 4'b1100, 1, 1, 1, 0, 0);

      #2 rst_n = 1'b0;
      #1 reset_check("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_game(1, 40);
      run_game(2, 37);

      @(negedge clk);
      rst_n = 1'b0;
      #1 reset_check("midrun reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_game(3, 27);

      chk("leftover expectations", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/whack_game_engine.md
WHACK_GAME_ENGINE -- requirements
Module: whack_game_engine

Interface
REQ-001 Parameter N_CH, default 4: number of target channels, range 1..16.
REQ-002 Parameter TICK_DIV, default 1000000: clk cycles per game tick, minimum 2.
REQ-003 Parameter ON_TICKS, default 50: ticks a lit target stays lit, minimum 1.
REQ-004 Parameter OFF_BASE, default 150: minimum dark ticks between lightings, minimum 1.
REQ-005 Parameter OFF_MASK, default 255: mask on the random extra dark ticks, 0 disables randomisation.
REQ-006 Parameter MISS_LIMIT, default 10: miss count that ends the game, minimum 1.
REQ-007 Parameter SCORE_W, default 16: score width.
REQ-008 Parameter PENALTY, default 0: 1 counts a press on an unlit target as a miss.
REQ-009 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value, nonzero.
REQ-010 clk  in  1  the single clock; all state on its rising edge.
REQ-011 rst_n  in  1  reset, asynchronous, active-low.
REQ-012 btn_n  in  N_CH  target buttons, active-low, asynchronous to clk.
REQ-013 start_n  in  1  start button, active-low, asynchronous.
REQ-014 lamp  out  N_CH  1 = target lit.
REQ-015 score  out  SCORE_W  hits this game.
REQ-016 miss  out  8  misses this game.
REQ-017 running  out  1  FSM in RUN.
REQ-018 game_over  out  1  FSM in OVER.
REQ-019 hit_pulse  out  1  one-cycle strobe on any scoring hit.

Function
REQ-020 Every button input SHALL pass through a 2-flop synchroniser followed by a falling-edge detector; only the edge-detected press is used.
REQ-021 The game FSM SHALL have states IDLE, RUN and OVER; IDLE/OVER -> RUN on a start press; RUN -> OVER in the cycle after miss reaches MISS_LIMIT; a start press in RUN is ignored.
REQ-022 Entering RUN SHALL clear score, miss and the prescaler, and place every channel in DARK, loading a dark count of OFF_BASE + i (i = channel index) to stagger the targets.
REQ-023 Tick SHALL be a one-cycle pulse when the prescaler equals TICK_DIV-1, with the prescaler wrapping to 0; ticks SHALL occur only in RUN.
REQ-024 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per tick.
REQ-025 Channel DARK: decrement on each tick; on a tick with count==1 go LIT, set lamp[i]=1 and load ON_TICKS.
REQ-026 Channel LIT: decrement on each tick; on a tick with count==1 go DARK, clear lamp[i], add 1 miss and load the dark count.
REQ-027 The dark count on every LIT->DARK transition SHALL be OFF_BASE + ((lfsr >> i) & OFF_MASK).
REQ-028 A press on a LIT channel SHALL be a hit: next edge lamp[i]=0, channel to DARK with a new dark count, score incremented, hit_pulse=1 for one cycle.
REQ-029 Pin-to-lamp latency SHALL be 3 clk edges from the btn_n falling edge (2 synchroniser edges + 1 register edge).
REQ-030 If a hit and a timeout occur on the same channel in the same cycle, the hit SHALL win and no miss is counted.
REQ-031 Simultaneous hits on k channels SHALL add k to score in one cycle; simultaneous misses SHALL add their count to miss in the same way.
REQ-032 Score SHALL saturate at 2^SCORE_W-1 and miss SHALL saturate at MISS_LIMIT; neither wraps.
REQ-033 With PENALTY=1, a press on a DARK channel SHALL count as a miss; with PENALTY=0 it SHALL be ignored; in both cases the channel state is unchanged.
REQ-034 In IDLE and OVER all lamps SHALL be 0, channels frozen, and score/miss held for display; button presses SHALL have no effect.

Reset
REQ-035 Asserting rst_n=0 SHALL immediately force FSM=IDLE, lamp=0, score=0, miss=0, hit_pulse=0, running=0, game_over=0, prescaler=0, lfsr=LFSR_SEED, and clear synchronisers to 1 (released).
REQ-036 Asserting reset mid-game SHALL discard all game state; after deassertion the block SHALL wait in IDLE for a start press.

Verification (N_CH=4, TICK_DIV=4, ON_TICKS=3, OFF_BASE=2, OFF_MASK=0, MISS_LIMIT=3)
REQ-037 Start press, no buttons -> lamp[0] lit after 2 ticks and lamp[1] after 3 ticks; each lamp drops after 3 lit ticks with miss +1; after the 3rd miss, game_over=1 and lamps=0.
REQ-038 Press btn_n[0] while lamp[0]=1 -> lamp[0]=0 exactly 3 clk edges later, score=1, one hit_pulse, miss unchanged.
REQ-039 Press btn_n[0] in the same cycle its timeout tick lands -> score+1, miss+0.
REQ-040 Press btn_n[1..2] in the same cycle while both are lit -> score +2 in one cycle; with PENALTY=1, a dark-channel press -> miss +1 and the lamp unchanged.
REQ-041 Pulse rst_n low mid-RUN -> all outputs 0 asynchronously; start press afterwards -> score=0, the stagger pattern restarts.
REQ-042 SCORE_W=2, 5 hits -> score holds at 3.
